// File: rtl/rv_decode_exec_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rv_decode_exec_pkg
// Brief    : Shared control encodings for the multicycle RV32I controller:
//            ALU ops, write-back sources, memory widths, next-PC selects,
//            sequencer states and base opcodes.
// Revision : 1.0 - initial release
// ============================================================================
package rv_decode_exec_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_SLL  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_SLT  = 4'd8,
        ALU_OP_SLTU = 4'd9
    } aluOp_e;

    typedef enum logic [1:0] {
        REG_SOURCE_ALU       = 2'd0,
        REG_SOURCE_MEMORY    = 2'd1,
        REG_SOURCE_IMMEDIATE = 2'd2
    } regSource_e;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE      = 2'd0,
        MEM_ACCESS_HALF_WORD = 2'd1,
        MEM_ACCESS_WORD      = 2'd2
    } memAccess_e;

    typedef enum logic [1:0] {
        NEXT_PC_PLUS4  = 2'd0,
        NEXT_PC_JAL    = 2'd1,
        NEXT_PC_JALR   = 2'd2,
        NEXT_PC_BRANCH = 2'd3
    } nextPc_e;

    typedef enum logic {
        ALU_B_SOURCE_REG = 1'b0,
        ALU_B_SOURCE_IMM = 1'b1
    } aluBSource_e;

    // Sequencer states; the sequencer itself lives outside this block.
    typedef enum logic [2:0] {
        STATE_IF  = 3'd0,
        STATE_ID  = 3'd1,
        STATE_EXE = 3'd2,
        STATE_MEM = 3'd3,
        STATE_WB  = 3'd4
    } state_e;

    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;

    // Maps funct3 plus the funct7[5] "alternate" bit to an ALU op for OP/OP-IMM.
    function automatic aluOp_e aluOpFromFunct(input logic [2:0] funct3, input logic alt);
        aluOp_e op;
        case (funct3)
            3'd0:    op = alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'd1:    op = ALU_OP_SLL;
            3'd2:    op = ALU_OP_SLT;
            3'd3:    op = ALU_OP_SLTU;
            3'd4:    op = ALU_OP_XOR;
            3'd5:    op = alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'd6:    op = ALU_OP_OR;
            default: op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_decode_exec_if.sv
`default_nettype none
// ============================================================================
// Interface : rv_decode_exec_if
// Brief     : Instruction/operand inputs and decoded control outputs of the
//             decode/execute core. master = glue/sequencer side, slave = core.
// Revision  : 1.0 - initial release
// ============================================================================
interface rv_decode_exec_if;
    logic        iwLoad;
    logic [31:0] iwInstr;
    logic        iwCheck;
    logic [31:0] iwPc;
    logic [31:0] iwRs1Val;
    logic [31:0] iwRs2Val;
    logic [4:0]  owRs1;
    logic [4:0]  owRs2;
    logic [4:0]  owRd;
    logic        owRegWrite;
    logic [1:0]  owWbSrc;
    logic [31:0] owWbImm;
    logic [31:0] owAluResult;
    logic        owAluZero;
    logic        owAluSign;
    logic        owMemWrite;
    logic        owMemSext;
    logic [1:0]  owMemAccess;
    logic        owExe;
    logic        owMem;
    logic        owWb;
    logic [31:0] owNextPc;
    logic        orHalted;

    modport master (
        output iwLoad, iwInstr, iwCheck, iwPc, iwRs1Val, iwRs2Val,
        input  owRs1, owRs2, owRd, owRegWrite, owWbSrc, owWbImm, owAluResult,
               owAluZero, owAluSign, owMemWrite, owMemSext, owMemAccess,
               owExe, owMem, owWb, owNextPc, orHalted
    );

    modport slave (
        input  iwLoad, iwInstr, iwCheck, iwPc, iwRs1Val, iwRs2Val,
        output owRs1, owRs2, owRd, owRegWrite, owWbSrc, owWbImm, owAluResult,
               owAluZero, owAluSign, owMemWrite, owMemSext, owMemAccess,
               owExe, owMem, owWb, owNextPc, orHalted
    );
endinterface
`default_nettype wire

// File: rtl/rv_decode_exec_alu.sv
`default_nettype none
// ============================================================================
// Module   : rv_alu
// Brief    : Combinational RV32I ALU with zero and sign flags.
// Revision : 1.0 - initial release
// ============================================================================
module rv_alu
    import rv_decode_exec_pkg::*;
(
    input  aluOp_e      i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_sign
);
    logic [31:0] w_result;

    // Operation select; shifts use only the low five bits of B.
    always_comb begin
        w_result = i_a + i_b;
        case (i_op)
            ALU_OP_ADD:  w_result = i_a + i_b;
            ALU_OP_SUB:  w_result = i_a - i_b;
            ALU_OP_AND:  w_result = i_a & i_b;
            ALU_OP_OR:   w_result = i_a | i_b;
            ALU_OP_XOR:  w_result = i_a ^ i_b;
            ALU_OP_SLL:  w_result = i_a << i_b[4:0];
            ALU_OP_SRL:  w_result = i_a >> i_b[4:0];
            ALU_OP_SRA:  w_result = $signed(i_a) >>> i_b[4:0];
            ALU_OP_SLT:  w_result = {31'd0, $signed(i_a) < $signed(i_b)};
            ALU_OP_SLTU: w_result = {31'd0, i_a < i_b};
            default:     w_result = i_a + i_b;
        endcase
    end

    assign o_result = w_result;
    assign o_zero   = (w_result == 32'd0);
    assign o_sign   = w_result[31];
endmodule
`default_nettype wire

// File: rtl/rv_decode_exec.sv
`default_nettype none
// ============================================================================
// Module   : rv_decode_exec
// Brief    : Decode/execute core of the multicycle RV32I controller. Holds the
//            instruction register, decodes control and immediates, drives the
//            ALU, computes the next PC and keeps a sticky illegal-instr halt.
// Revision : 1.0 - initial release
// ============================================================================
module rv_decode_exec
    import rv_decode_exec_pkg::*;
#(
    parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
    input  logic             iwClk,
    input  logic             iwRst,
    rv_decode_exec_if.slave  bus
);
    logic [31:0] r_instr;
    logic        r_halted;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_rd;
    logic [31:0] w_immI, w_immS, w_immB, w_immJ, w_immU;
    logic        w_illegal, w_regWrite, w_memWrite, w_memSext;
    logic        w_exe, w_mem, w_wb, w_invert, w_taken;
    logic [1:0]  w_memAccess;
    regSource_e  w_wbSrc;
    aluOp_e      w_aluOp;
    aluBSource_e w_bSrc;
    nextPc_e     w_nextSel;
    logic [31:0] w_wbImm, w_bImm, w_aluB, w_aluResult, w_pcPlus4, w_nextPc;
    logic        w_aluZero, w_aluSign;

    assign w_opcode  = r_instr[6:0];
    assign w_f3      = r_instr[14:12];
    assign w_f7      = r_instr[31:25];
    assign w_rd      = r_instr[11:7];
    assign w_immI    = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_immS    = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_immB    = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_immJ    = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
    assign w_immU    = {r_instr[31:12], 12'd0};
    assign w_pcPlus4 = bus.iwPc + 32'd4;

    // Instruction register and sticky halt; loads are frozen once halted.
    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            r_instr  <= RESET_INSTR;
            r_halted <= 1'b0;
        end else begin
            if (bus.iwLoad && !r_halted)
                r_instr <= bus.iwInstr;
            if (bus.iwCheck && w_illegal)
                r_halted <= 1'b1;
        end
    end

    // Opcode decode into legality, write-back, ALU, memory and stage controls.
    always_comb begin
        w_illegal   = 1'b1;
        w_regWrite  = 1'b0;
        w_wbSrc     = REG_SOURCE_ALU;
        w_wbImm     = 32'd0;
        w_aluOp     = ALU_OP_ADD;
        w_bSrc      = ALU_B_SOURCE_IMM;
        w_bImm      = w_immI;
        w_memWrite  = 1'b0;
        w_memSext   = 1'b0;
        w_memAccess = MEM_ACCESS_WORD;
        w_exe       = 1'b0;
        w_mem       = 1'b0;
        w_wb        = 1'b0;
        w_nextSel   = NEXT_PC_PLUS4;
        case (w_opcode)
            c_OPC_LUI: begin
                w_illegal  = 1'b0;
                w_regWrite = 1'b1;
                w_wbSrc    = REG_SOURCE_IMMEDIATE;
                w_wbImm    = w_immU;
            end
            c_OPC_AUIPC: begin
                w_illegal  = 1'b0;
                w_regWrite = 1'b1;
                w_wbSrc    = REG_SOURCE_IMMEDIATE;
                w_wbImm    = bus.iwPc + w_immU;
            end
            c_OPC_JAL: begin
                w_illegal  = 1'b0;
                w_regWrite = 1'b1;
                w_wbSrc    = REG_SOURCE_IMMEDIATE;
                w_wbImm    = w_pcPlus4;
                w_nextSel  = NEXT_PC_JAL;
            end
            c_OPC_JALR: begin
                // Link is written in ID; the ALU forms rs1+imm for the target.
                w_illegal  = (w_f3 != 3'd0);
                w_regWrite = 1'b1;
                w_wbSrc    = REG_SOURCE_IMMEDIATE;
                w_wbImm    = w_pcPlus4;
                w_exe      = 1'b1;
                w_nextSel  = NEXT_PC_JALR;
            end
            c_OPC_BRANCH: begin
                w_illegal = (w_f3[2:1] == 2'b01);
                w_bSrc    = ALU_B_SOURCE_REG;
                w_exe     = 1'b1;
                w_nextSel = NEXT_PC_BRANCH;
                case (w_f3[2:1])
                    2'b10:   w_aluOp = ALU_OP_SLT;
                    2'b11:   w_aluOp = ALU_OP_SLTU;
                    default: w_aluOp = ALU_OP_SUB;
                endcase
            end
            c_OPC_LOAD: begin
                w_illegal   = (w_f3[1:0] == 2'b11) || (w_f3[2] && w_f3[1]);
                w_regWrite  = 1'b1;
                w_wbSrc     = REG_SOURCE_MEMORY;
                w_memSext   = ~w_f3[2];
                w_memAccess = w_f3[1:0];
                w_exe       = 1'b1;
                w_mem       = 1'b1;
                w_wb        = 1'b1;
            end
            c_OPC_STORE: begin
                w_illegal   = w_f3[2] || (w_f3[1:0] == 2'b11);
                w_bImm      = w_immS;
                w_memWrite  = 1'b1;
                w_memAccess = w_f3[1:0];
                w_exe       = 1'b1;
                w_mem       = 1'b1;
            end
            c_OPC_OPIMM: begin
                // Shift-immediates carry funct7; only SRAI may set bit 30.
                if (w_f3 == 3'd1)
                    w_illegal = (w_f7 != 7'd0);
                else if (w_f3 == 3'd5)
                    w_illegal = (w_f7 != 7'd0) && (w_f7 != 7'b0100000);
                else
                    w_illegal = 1'b0;
                w_aluOp    = aluOpFromFunct(w_f3, (w_f3 == 3'd5) && w_f7[5]);
                w_regWrite = 1'b1;
                w_exe      = 1'b1;
                w_wb       = 1'b1;
            end
            c_OPC_OP: begin
                w_illegal  = !((w_f7 == 7'd0) ||
                               ((w_f7 == 7'b0100000) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
                w_bSrc     = ALU_B_SOURCE_REG;
                w_aluOp    = aluOpFromFunct(w_f3, w_f7[5]);
                w_regWrite = 1'b1;
                w_exe      = 1'b1;
                w_wb       = 1'b1;
            end
            c_OPC_FENCE: begin
                w_illegal = 1'b0;
            end
            default: ;
        endcase
        if (w_rd == 5'd0)
            w_regWrite = 1'b0;
    end

    assign w_aluB = (w_bSrc == ALU_B_SOURCE_REG) ? bus.iwRs2Val : w_bImm;

    rv_alu u_alu (
        .i_op     (w_aluOp),
        .i_a      (bus.iwRs1Val),
        .i_b      (w_aluB),
        .o_result (w_aluResult),
        .o_zero   (w_aluZero),
        .o_sign   (w_aluSign)
    );

    // Branch resolution and next-PC select; BEQ/BGE/BGEU take on a zero compare.
    always_comb begin
        w_invert = (w_f3 == 3'd0) || (w_f3 == 3'd5) || (w_f3 == 3'd7);
        w_taken  = (~w_aluZero) ^ w_invert;
        w_nextPc = w_pcPlus4;
        case (w_nextSel)
            NEXT_PC_JAL:    w_nextPc = bus.iwPc + w_immJ;
            NEXT_PC_JALR:   w_nextPc = {w_aluResult[31:1], 1'b0};
            NEXT_PC_BRANCH: w_nextPc = w_taken ? (bus.iwPc + w_immB) : w_pcPlus4;
            default:        w_nextPc = w_pcPlus4;
        endcase
    end

    assign bus.owRs1       = r_instr[19:15];
    assign bus.owRs2       = r_instr[24:20];
    assign bus.owRd        = w_rd;
    assign bus.owRegWrite  = w_regWrite;
    assign bus.owWbSrc     = w_wbSrc;
    assign bus.owWbImm     = w_wbImm;
    assign bus.owAluResult = w_aluResult;
    assign bus.owAluZero   = w_aluZero;
    assign bus.owAluSign   = w_aluSign;
    assign bus.owMemWrite  = w_memWrite;
    assign bus.owMemSext   = w_memSext;
    assign bus.owMemAccess = w_memAccess;
    assign bus.owExe       = w_exe;
    assign bus.owMem       = w_mem;
    assign bus.owWb        = w_wb;
    assign bus.owNextPc    = w_nextPc;
    assign bus.orHalted    = r_halted;
endmodule
`default_nettype wire

// File: tb/tb_rv_decode_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_decode_exec
// Brief    : Self-checking bench for rv_decode_exec with an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_decode_exec;
    logic iwClk = 1'b0;
    logic iwRst = 1'b1;
    int   nChecks = 0;
    int   nFails  = 0;

    typedef struct {
        logic [31:0] aluResult;
        logic [31:0] nextPc;
        logic [31:0] wbImm;
        logic [4:0]  rd;
        logic        regWrite;
        logic [1:0]  wbSrc;
        logic        exe;
        logic        mem;
        logic        wb;
    } exp_t;

    exp_t sb[$];

    rv_decode_exec_if bus ();

    rv_decode_exec #(.RESET_INSTR(32'h00000013)) dut (
        .iwClk (iwClk),
        .iwRst (iwRst),
        .bus   (bus)
    );

    always #5 iwClk = ~iwClk;

    // Independent reference for the register-register ALU operations.
    function automatic logic [31:0] refOp(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic loadInstr(input logic [31:0] instr);
        bus.iwInstr = instr;
        bus.iwLoad  = 1'b1;
        @(posedge iwClk);
        #1;
        bus.iwLoad  = 1'b0;
    endtask

    task automatic pulseCheck();
        bus.iwCheck = 1'b1;
        @(posedge iwClk);
        #1;
        bus.iwCheck = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        bus.iwPc = 32'h80; bus.iwRs1Val = 32'd0; bus.iwRs2Val = 32'd0;
        iwRst = 1'b1;
        repeat (2) @(posedge iwClk);
        #1;
        iwRst = 1'b0;
        sb.push_back('{32'd0, 32'h84, 32'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1});
        @(posedge iwClk); #1;
        e = sb.pop_front();
        nChecks++; if (bus.owRd !== e.rd) begin nFails++; $display("FAIL reset_rd got %0d want %0d", bus.owRd, e.rd); end
        nChecks++; if (bus.owRegWrite !== e.regWrite) begin nFails++; $display("FAIL reset_regwrite got %0b want %0b", bus.owRegWrite, e.regWrite); end
        nChecks++; if (bus.owNextPc !== e.nextPc) begin nFails++; $display("FAIL reset_nextpc got %h want %h", bus.owNextPc, e.nextPc); end
        nChecks++; if (bus.orHalted !== 1'b0) begin nFails++; $display("FAIL reset_halted got %0b want 0", bus.orHalted); end
        nChecks++; if ({bus.owExe, bus.owMem, bus.owWb} !== {e.exe, e.mem, e.wb}) begin nFails++; $display("FAIL reset_stages got %b want %b", {bus.owExe, bus.owMem, bus.owWb}, {e.exe, e.mem, e.wb}); end
        nChecks++; if ({bus.owRs1, bus.owRs2} !== 10'd0) begin nFails++; $display("FAIL reset_rs got %h want 0", {bus.owRs1, bus.owRs2}); end
    endtask

    task automatic test_addi();
        exp_t e;
        bus.iwPc = 32'h0; bus.iwRs1Val = 32'd0;
        sb.push_back('{32'd5, 32'd4, 32'd0, 5'd1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1});
        loadInstr(32'h00500093);
        e = sb.pop_front();
        nChecks++; if (bus.owAluResult !== e.aluResult) begin nFails++; $display("FAIL addi_alu got %h want %h", bus.owAluResult, e.aluResult); end
        nChecks++; if (bus.owRd !== e.rd || bus.owRegWrite !== e.regWrite) begin nFails++; $display("FAIL addi_rd got %0d/%0b want %0d/%0b", bus.owRd, bus.owRegWrite, e.rd, e.regWrite); end
        nChecks++; if (bus.owWbSrc !== e.wbSrc) begin nFails++; $display("FAIL addi_wbsrc got %0d want %0d", bus.owWbSrc, e.wbSrc); end
        nChecks++; if ({bus.owExe, bus.owMem, bus.owWb} !== {e.exe, e.mem, e.wb}) begin nFails++; $display("FAIL addi_stages got %b want %b", {bus.owExe, bus.owMem, bus.owWb}, {e.exe, e.mem, e.wb}); end
    endtask

    task automatic test_branch();
        exp_t e;
        // beq x1,x2,+8 at 0x100: taken then not taken
        bus.iwPc = 32'h100; bus.iwRs1Val = 32'd7; bus.iwRs2Val = 32'd7;
        sb.push_back('{32'd0, 32'h108, 32'd0, 5'd8, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
        sb.push_back('{32'd0, 32'h104, 32'd0, 5'd8, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
        loadInstr(32'h00208463);
        e = sb.pop_front();
        nChecks++; if (bus.owNextPc !== e.nextPc) begin nFails++; $display("FAIL beq_taken got %h want %h", bus.owNextPc, e.nextPc); end
        nChecks++; if (bus.owRegWrite !== e.regWrite || bus.owExe !== e.exe || bus.owWb !== e.wb) begin nFails++; $display("FAIL beq_ctrl got %b want %b", {bus.owRegWrite, bus.owExe, bus.owWb}, {e.regWrite, e.exe, e.wb}); end
        bus.iwRs2Val = 32'd8;
        #1;
        e = sb.pop_front();
        nChecks++; if (bus.owNextPc !== e.nextPc) begin nFails++; $display("FAIL beq_not_taken got %h want %h", bus.owNextPc, e.nextPc); end
        // blt x1,x2,-4 at pc 0: negative target wraps
        bus.iwPc = 32'h0; bus.iwRs1Val = 32'hFFFFFFFF; bus.iwRs2Val = 32'd0;
        sb.push_back('{32'd1, 32'hFFFFFFFC, 32'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
        sb.push_back('{32'd0, 32'h4, 32'd0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
        loadInstr(32'hFE20CEE3);
        e = sb.pop_front();
        nChecks++; if (bus.owNextPc !== e.nextPc || bus.owAluResult !== e.aluResult) begin nFails++; $display("FAIL blt_taken got %h/%h want %h/%h", bus.owNextPc, bus.owAluResult, e.nextPc, e.aluResult); end
        bus.iwRs1Val = 32'd5;
        #1;
        e = sb.pop_front();
        nChecks++; if (bus.owNextPc !== e.nextPc || bus.owAluResult !== e.aluResult) begin nFails++; $display("FAIL blt_not_taken got %h/%h want %h/%h", bus.owNextPc, bus.owAluResult, e.nextPc, e.aluResult); end
    endtask

    task automatic test_jumps();
        exp_t e;
        bus.iwPc = 32'h40; bus.iwRs1Val = 32'h200;
        sb.push_back('{32'h203, 32'h202, 32'h44, 5'd1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0});
        loadInstr(32'h003280E7);
        e = sb.pop_front();
        nChecks++; if (bus.owNextPc !== e.nextPc) begin nFails++; $display("FAIL jalr_nextpc got %h want %h", bus.owNextPc, e.nextPc); end
        nChecks++; if (bus.owWbImm !== e.wbImm || bus.owWbSrc !== e.wbSrc) begin nFails++; $display("FAIL jalr_wb got %h/%0d want %h/%0d", bus.owWbImm, bus.owWbSrc, e.wbImm, e.wbSrc); end
        nChecks++; if ({bus.owExe, bus.owMem, bus.owWb} !== {e.exe, e.mem, e.wb}) begin nFails++; $display("FAIL jalr_stages got %b want %b", {bus.owExe, bus.owMem, bus.owWb}, {e.exe, e.mem, e.wb}); end
        // jal x1,+16 near the top of memory: target wraps to 0x8
        bus.iwPc = 32'hFFFFFFF8;
        sb.push_back('{32'd0, 32'h8, 32'hFFFFFFFC, 5'd1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0});
        loadInstr(32'h010000EF);
        e = sb.pop_front();
        nChecks++; if (bus.owNextPc !== e.nextPc || bus.owWbImm !== e.wbImm) begin nFails++; $display("FAIL jal_wrap got %h/%h want %h/%h", bus.owNextPc, bus.owWbImm, e.nextPc, e.wbImm); end
        nChecks++; if ({bus.owExe, bus.owMem, bus.owWb} !== {e.exe, e.mem, e.wb}) begin nFails++; $display("FAIL jal_stages got %b want %b", {bus.owExe, bus.owMem, bus.owWb}, {e.exe, e.mem, e.wb}); end
        // lui x5,0x12345 and auipc x5,0x12345
        bus.iwPc = 32'h1000;
        sb.push_back('{32'd0, 32'h1004, 32'h12345000, 5'd5, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0});
        sb.push_back('{32'd0, 32'h1004, 32'h12346000, 5'd5, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0});
        loadInstr(32'h123452B7);
        e = sb.pop_front();
        nChecks++; if (bus.owWbImm !== e.wbImm || bus.owRd !== e.rd || bus.owExe !== e.exe) begin nFails++; $display("FAIL lui got %h/%0d/%0b want %h/%0d/%0b", bus.owWbImm, bus.owRd, bus.owExe, e.wbImm, e.rd, e.exe); end
        loadInstr(32'h12345297);
        e = sb.pop_front();
        nChecks++; if (bus.owWbImm !== e.wbImm || bus.owNextPc !== e.nextPc) begin nFails++; $display("FAIL auipc got %h/%h want %h/%h", bus.owWbImm, bus.owNextPc, e.wbImm, e.nextPc); end
    endtask

    task automatic test_load_store();
        exp_t e;
        bus.iwPc = 32'h0; bus.iwRs1Val = 32'h1000;
        sb.push_back('{32'hFFE, 32'h4, 32'd0, 5'd3, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1});
        loadInstr(32'hFFE21183);
        e = sb.pop_front();
        nChecks++; if (bus.owAluResult !== e.aluResult) begin nFails++; $display("FAIL lh_addr got %h want %h", bus.owAluResult, e.aluResult); end
        nChecks++; if (bus.owMemAccess !== 2'd1 || bus.owMemSext !== 1'b1 || bus.owMemWrite !== 1'b0) begin nFails++; $display("FAIL lh_mem got %b want 0110", {bus.owMemAccess, bus.owMemSext, bus.owMemWrite}); end
        nChecks++; if ({bus.owExe, bus.owMem, bus.owWb} !== {e.exe, e.mem, e.wb} || bus.owWbSrc !== e.wbSrc) begin nFails++; $display("FAIL lh_stages got %b/%0d want %b/%0d", {bus.owExe, bus.owMem, bus.owWb}, bus.owWbSrc, {e.exe, e.mem, e.wb}, e.wbSrc); end
        // sw x2,-4(x1): S-immediate split across fields
        bus.iwRs1Val = 32'h2000;
        sb.push_back('{32'h1FFC, 32'h4, 32'd0, 5'd28, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0});
        loadInstr(32'hFE20AE23);
        e = sb.pop_front();
        nChecks++; if (bus.owAluResult !== e.aluResult || bus.owMemWrite !== 1'b1 || bus.owMemAccess !== 2'd2) begin nFails++; $display("FAIL sw got %h/%b want %h/110", bus.owAluResult, {bus.owMemWrite, bus.owMemAccess}, e.aluResult); end
        nChecks++; if (bus.owRegWrite !== e.regWrite || {bus.owExe, bus.owMem, bus.owWb} !== {e.exe, e.mem, e.wb}) begin nFails++; $display("FAIL sw_ctrl got %b want %b", {bus.owRegWrite, bus.owExe, bus.owMem, bus.owWb}, {e.regWrite, e.exe, e.mem, e.wb}); end
    endtask

    task automatic test_alu_random();
        exp_t e;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            f3  = 3'($urandom_range(0, 7));
            alt = ((f3 == 3'd0) || (f3 == 3'd5)) ? 1'($urandom_range(0, 1)) : 1'b0;
            rd  = 5'($urandom_range(1, 31));
            a   = (i % 4 == 0) ? 32'h80000000 : $urandom;
            b   = (i % 5 == 0) ? 32'h0000001F : $urandom;
            bus.iwRs1Val = a; bus.iwRs2Val = b; bus.iwPc = 32'h200;
            sb.push_back('{refOp(f3, alt, a, b), 32'h204, 32'd0, rd, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1});
            loadInstr({1'b0, alt, 5'd0, 5'd2, 5'd1, f3, rd, 7'b0110011});
            e = sb.pop_front();
            nChecks++; if (bus.owAluResult !== e.aluResult || bus.owRd !== e.rd) begin nFails++; $display("FAIL alu_op f3=%0d alt=%0b got %h rd %0d want %h rd %0d", f3, alt, bus.owAluResult, bus.owRd, e.aluResult, e.rd); end
            nChecks++; if (bus.owAluZero !== (e.aluResult == 32'd0) || bus.owAluSign !== e.aluResult[31]) begin nFails++; $display("FAIL alu_flags got %b want %b", {bus.owAluZero, bus.owAluSign}, {e.aluResult == 32'd0, e.aluResult[31]}); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [11:0] imms [6] = '{12'd0, 12'd1, 12'h7FF, 12'h800, 12'hFFF, 12'h123};
        bus.iwRs1Val = 32'd0; bus.iwPc = 32'h10;
        bus.iwLoad = 1'b1;
        foreach (imms[i]) begin
            sb.push_back('{{{20{imms[i][11]}}, imms[i]}, 32'h14, 32'd0, 5'd1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1});
        end
        foreach (imms[i]) begin
            bus.iwInstr = {imms[i], 5'd0, 3'd0, 5'd1, 7'b0010011};
            @(posedge iwClk); #1;
            e = sb.pop_front();
            nChecks++; if (bus.owAluResult !== e.aluResult) begin nFails++; $display("FAIL b2b_addi[%0d] got %h want %h", i, bus.owAluResult, e.aluResult); end
        end
        bus.iwLoad = 1'b0;
    endtask

    task automatic test_halt();
        logic [31:0] bad [3] = '{32'h00000073, 32'h02208033, 32'h40209093};
        // legal instruction under check must not halt
        loadInstr(32'h00500093);
        pulseCheck();
        nChecks++; if (bus.orHalted !== 1'b0) begin nFails++; $display("FAIL halt_legal got %0b want 0", bus.orHalted); end
        // all-zero word halts only once checked
        bus.iwRs1Val = 32'd0;
        loadInstr(32'h00000000);
        nChecks++; if (bus.orHalted !== 1'b0) begin nFails++; $display("FAIL halt_before_check got %0b want 0", bus.orHalted); end
        pulseCheck();
        nChecks++; if (bus.orHalted !== 1'b1) begin nFails++; $display("FAIL halt_set got %0b want 1", bus.orHalted); end
        loadInstr(32'h00500093);
        loadInstr(32'h00000013);
        repeat (3) @(posedge iwClk);
        #1;
        nChecks++; if (bus.orHalted !== 1'b1) begin nFails++; $display("FAIL halt_sticky got %0b want 1", bus.orHalted); end
        nChecks++; if (bus.owRd !== 5'd0 || bus.owAluResult !== 32'd0) begin nFails++; $display("FAIL halt_load_ignored got rd %0d alu %h want rd 0 alu 0", bus.owRd, bus.owAluResult); end
        iwRst = 1'b1; @(posedge iwClk); #1; iwRst = 1'b0;
        nChecks++; if (bus.orHalted !== 1'b0) begin nFails++; $display("FAIL halt_cleared got %0b want 0", bus.orHalted); end
        // ecall, OP with funct7=1, slli with funct7=0x20 are all illegal
        foreach (bad[i]) begin
            loadInstr(bad[i]);
            pulseCheck();
            nChecks++; if (bus.orHalted !== 1'b1) begin nFails++; $display("FAIL halt_illegal[%0d] got %0b want 1", i, bus.orHalted); end
            iwRst = 1'b1; @(posedge iwClk); #1; iwRst = 1'b0;
        end
    endtask

    initial begin
        bus.iwLoad = 1'b0; bus.iwCheck = 1'b0; bus.iwInstr = 32'd0;
        bus.iwPc = 32'd0; bus.iwRs1Val = 32'd0; bus.iwRs2Val = 32'd0;
        test_reset();
        test_addi();
        test_branch();
        test_jumps();
        test_load_store();
        test_alu_random();
        test_back_to_back();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
`default_nettype wire
